// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction memory, redirect and output stream bundle for fetch_unit
interface fetch_unit_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] imem_address;
  logic [WIDTH-1:0] imem_instruction;
  logic             imem_done;
  logic             redirect_valid;
  logic [WIDTH-1:0] redirect_target;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_instr;
  logic [WIDTH-1:0] out_pc;

  modport master (
    output imem_address, out_valid, out_instr, out_pc,
    input  imem_instruction, imem_done, redirect_valid, redirect_target, out_ready
  );

  modport slave (
    input  imem_address, out_valid, out_instr, out_pc,
    output imem_instruction, imem_done, redirect_valid, redirect_target, out_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - sequential instruction fetcher with one-entry output register and redirect
module fetch_unit #(
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] RESET_PC = 16'h0000
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         enable,
  fetch_unit_if.master bus,
  output logic         halted,
  output logic [15:0]  fetch_count
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, HALT} state_t;

  state_t           state;
  logic [WIDTH-1:0] pc;
  logic             valid_q;
  logic [WIDTH-1:0] instr_q;
  logic [WIDTH-1:0] opc_q;
  logic             load_slot;
  logic             consumed;

  assign load_slot        = !valid_q || bus.out_ready;
  assign consumed         = valid_q && bus.out_ready;
  assign bus.imem_address = pc;
  assign bus.out_valid    = valid_q;
  assign bus.out_instr    = instr_q;
  assign bus.out_pc       = opc_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      valid_q     <= 1'b0;
      instr_q     <= '0;
      opc_q       <= '0;
      halted      <= 1'b0;
      fetch_count <= 16'h0000;
    end else if (state == IDLE) begin
      if (enable) state <= RUN;
    end else if (bus.redirect_valid) begin
      // Redirect flushes the pending word even if it is being accepted this cycle
      pc      <= bus.redirect_target;
      valid_q <= 1'b0;
      halted  <= 1'b0;
      state   <= RUN;
    end else begin
      case (state)
        RUN: begin
          if (bus.imem_done) begin
            if (consumed) valid_q <= 1'b0;
            state <= DRAIN;
          end else if (load_slot) begin
            instr_q <= bus.imem_instruction;
            opc_q   <= pc;
            valid_q <= 1'b1;
            pc      <= pc + WIDTH'(1);
            if (fetch_count != 16'hFFFF) fetch_count <= fetch_count + 16'd1;
          end
        end
        DRAIN: begin
          if (!valid_q || consumed) begin
            valid_q <= 1'b0;
            halted  <= 1'b1;
            state   <= HALT;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the instruction and address width (matches `WORD_VEC).
REQ-002 SHALL have parameter RESET_PC, default 16'h0000, giving the first fetch address.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, the asynchronous active-low reset.
REQ-005 SHALL have port enable, input, 1, which starts fetching from IDLE.
REQ-006 SHALL have port imem_address, output, WIDTH, the address to instruction memory; equals pc combinationally.
REQ-007 SHALL have port imem_instruction, input, WIDTH, the combinational read data for imem_address.
REQ-008 SHALL have port imem_done, input, 1, high when imem_address is past the last program word.
REQ-009 SHALL have port redirect_valid, input, 1, a branch/jump request from downstream.
REQ-010 SHALL have port redirect_target, input, WIDTH, the new pc for the redirect.
REQ-011 SHALL have port out_valid, output, 1, high when out_instr/out_pc hold a fetched word.
REQ-012 SHALL have port out_ready, input, 1, the downstream accept.
REQ-013 SHALL have port out_instr, output, WIDTH, the fetched instruction.
REQ-014 SHALL have port out_pc, output, WIDTH, the address of out_instr.
REQ-015 SHALL have port halted, output, 1, high only in the HALT state.
REQ-016 SHALL have port fetch_count, output, 16, the number of words captured since reset.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, DRAIN and HALT.
REQ-018 IDLE SHALL go to RUN on enable=1; no capture occurs in IDLE, and enable is ignored in every other state.
REQ-019 "load slot" SHALL be defined as out_valid==0 or out_ready==1.
REQ-020 In RUN with load slot, imem_done=0 and no redirect, the block SHALL capture out_instr<=imem_instruction and out_pc<=pc, set out_valid<=1, set pc<=pc+1, and increment fetch_count; fetch-to-output latency is 1 cycle.
REQ-021 In RUN without load slot, pc, out_* and fetch_count SHALL hold, and out_instr/out_pc SHALL stay stable while out_valid=1 and out_ready=0.
REQ-022 A word SHALL be consumed when out_valid and out_ready are both 1 on a clock edge; if nothing new is captured, out_valid<=0.
REQ-023 In RUN with imem_done=1 and no redirect, the block SHALL capture nothing, hold pc, and go to DRAIN; a pending word still completes its handshake.
REQ-024 DRAIN SHALL go to HALT on the first cycle where out_valid==0, or where out_valid and out_ready are both 1.
REQ-025 HALT SHALL hold all state with out_valid=0 and halted=1.
REQ-026 redirect_valid=1 in RUN, DRAIN or HALT SHALL have highest priority: pc<=redirect_target, out_valid<=0 (flush, even if out_ready=1 that cycle), no capture, fetch_count unchanged, and next state RUN.
REQ-027 redirect_valid SHALL be ignored in IDLE.
REQ-028 pc SHALL increment modulo 2^WIDTH (16'hFFFF -> 16'h0000).
REQ-029 fetch_count SHALL saturate at 16'hFFFF.

Reset
REQ-030 While reset_n=0, the block SHALL asynchronously set state=IDLE, pc=RESET_PC, out_valid=0, out_instr=0, out_pc=0, halted=0 and fetch_count=0, including when reset is asserted mid-fetch or mid-handshake.
REQ-031 The first capture after reset_n deasserts SHALL occur no earlier than the cycle after enable is sampled high.

Verification
REQ-032 Reset, then enable with out_ready=1 held and memory words 6200, 6301, 6C01 with done at address 3 -> out_pc 0,1,2 on consecutive cycles, then DRAIN, then halted=1, fetch_count=3.
REQ-033 out_ready=0 for 5 cycles after the first capture -> out_instr=6200 and out_pc=0 stable, pc=1, fetch_count=1 throughout.
REQ-034 redirect_valid=1 with target=0004 while out_valid=1 and out_ready=1 -> next cycle out_valid=0 and pc=4; the following capture has out_pc=4.
REQ-035 From HALT, redirect with target=0000 -> state RUN, halted=0, fetching restarts at address 0.
REQ-036 With pc preloaded to FFFF via redirect and done=0 -> capture out_pc=FFFF, then out_pc=0000.
REQ-037 reset_n pulsed low mid-stream, asynchronously to clk -> all outputs zero immediately, state IDLE, and no capture until enable is seen.
